seq_bam_mul: RTL and testbench



---
 rtl/seq_bam_pkg.sv | 39 +++
 rtl/bam_row_gen.sv | 31 +++
 rtl/seq_bam_mul.sv | 97 +++++++++
 tb/tb_seq_bam_mul.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_bam_pkg.sv
// Shared types and helpers for the sequential broken-array multiplier.
package seq_bam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the horizontal cut: must hold 0..n.
  function automatic int hw_of(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of the vertical cut: must hold 0..2n.
  function automatic int vw_of(input int n);
    return $clog2(2 * n + 1);
  endfunction

  // Reference product: every a[i]&b[j] term kept when j >= h and i+j >= v.
  // Operands are carried in 64 bits, so this is valid for n <= 32.
  function automatic longint unsigned bam_model(input int n,
                                                input longint unsigned a,
                                                input longint unsigned b,
                                                input int h,
                                                input int v);
    longint unsigned p;
    p = 0;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < n; i++) begin
        if (a[i] && b[j] && (j >= h) && (i + j >= v)) begin
          p += 64'(1) << (i + j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bam_row_gen.sv
// One partial-product row: multiplicand masked by the vertical cut,
// shifted to row position j, and gated by the multiplier bit b[j].
module bam_row_gen
  import seq_bam_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]              i_a,
  input  logic                      i_b_bit,
  input  logic [$clog2(N+1)-1:0]    i_j,
  input  logic [$clog2(2*N+1)-1:0]  i_v,
  output logic [2*N-1:0]            o_row
);

  logic [N-1:0] w_mask;

  // Column i survives the vertical cut when its weight i+j reaches v.
  always_comb begin
    // NOTE: assign a default before the loop so every bit is written on every
    // pass; a partially-assigned variable in always_comb infers a latch.
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (32'(i) + 32'(i_j)) >= 32'(i_v);
    end
  end

  // Zero-extend the masked multiplicand to full product width before shifting
  // so the top row can reach bit 2N-1 without truncation.
  assign o_row = i_b_bit ? ({{N{1'b0}}, i_a & w_mask} << i_j) : '0;

endmodule

// File: rtl/seq_bam_mul.sv
// Sequential runtime-configurable broken-array multiplier: one partial-product
// row per clock, cuts h/v supplied with each operation, valid/ready on both sides.
module seq_bam_mul
  import seq_bam_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_a,
  input  logic [N-1:0]              in_b,
  input  logic [$clog2(N+1)-1:0]    in_h,
  input  logic [$clog2(2*N+1)-1:0]  in_v,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*N-1:0]            out_p
);

  localparam int HW = hw_of(N);
  localparam int VW = vw_of(N);
  localparam logic [HW-1:0] LP_N    = HW'(N);
  localparam logic [HW-1:0] LP_LAST = HW'(N - 1);

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [VW-1:0]    r_v;
  logic [HW-1:0]    r_j;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   w_row;
  logic             w_b_bit;
  logic             w_accept;
  logic             w_step;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_step   = (r_state == ST_BUSY) && (r_j < LP_N);
  // A shift past the top bit yields 0, so rows j >= N contribute nothing.
  assign w_b_bit  = |(r_b & (N'(1) << r_j));

  bam_row_gen #(.N(N)) u_row_gen (
    .i_a     (r_a),
    .i_b_bit (w_b_bit),
    .i_j     (r_j),
    .i_v     (r_v),
    .o_row   (w_row)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: BUSY exits after row N-1, or at once when the cut skips every row.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)      w_next = ST_BUSY;
      ST_BUSY: if (r_j >= LP_LAST) w_next = ST_DONE;
      ST_DONE: if (out_ready)     w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  // Operand capture on accept, then one row accumulated per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is reset so an aborted operation leaves
    // no stale operand or partial sum behind.
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_v   <= '0;
      r_j   <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_v   <= in_v;
      r_j   <= in_h;
      r_acc <= '0;
    end else if (w_step) begin
      r_acc <= r_acc + w_row;
      r_j   <= r_j + HW'(1);
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  // Product is only presented while valid; partial sums stay internal.
  assign out_p     = out_valid ? r_acc : '0;

endmodule

// File: tb/tb_seq_bam_mul.sv
// Self-checking bench for seq_bam_mul: directed corner cases, stall and
// mid-operation reset, then randomized operations against a sum-of-terms model.
module tb_seq_bam_mul;

  localparam int N  = 8;
  localparam int HW = $clog2(N + 1);
  localparam int VW = $clog2(2 * N + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_a;
  logic [N-1:0]      in_b;
  logic [HW-1:0]     in_h;
  logic [VW-1:0]     in_v;
  logic              out_valid;
  logic              out_ready;
  logic [2*N-1:0]    out_p;

  int n_checks = 0;
  int n_fail   = 0;

  seq_bam_mul #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_h      (in_h),
    .in_v      (in_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sum of every kept a[i]*b[j]*2^(i+j) term, straight from the definition.
  function automatic logic [2*N-1:0] ref_bam(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input int h, input int v);
    logic [2*N-1:0] p;
    p = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if (a[i] && b[j] && j >= h && i + j >= v)
          p += (2*N)'(1) << (i + j);
    return p;
  endfunction

  // One full operation: accept, wait for result, optional stall with ignored
  // requests, then handshake and confirm release.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int h, input int v, input int stall, input bit poke);
    logic [2*N-1:0] exp_p;
    logic [2*N-1:0] held;
    int exp_lat;
    int lat;
    exp_p   = ref_bam(a, b, h, v);
    exp_lat = (h >= N) ? 1 : (N - h);
    @(negedge clk);
    check({tag, "/ready_before"}, 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_h = HW'(h); in_v = VW'(v); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = N'($urandom); in_b = N'($urandom);
    in_h = HW'($urandom); in_v = VW'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/product"}, 64'(out_p), 64'(exp_p));
    check({tag, "/ready_done"}, 64'(in_ready), 64'd0);
    held = out_p;
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        in_valid = 1'b1;
        in_a = N'($urandom); in_b = N'($urandom);
        in_h = '0; in_v = '0;
      end
      @(posedge clk); #1;
      check({tag, "/stall_valid"}, 64'(out_valid), 64'd1);
      check({tag, "/stall_p"}, 64'(out_p), 64'(held));
      check({tag, "/stall_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/release_valid"}, 64'(out_valid), 64'd0);
    check({tag, "/release_ready"}, 64'(in_ready), 64'd1);
    check({tag, "/release_p"}, 64'(out_p), 64'd0);
  endtask

  initial begin
    int h_r;
    int v_r;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_h = '0; in_v = '0;
    #23;
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/out_p", 64'(out_p), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed corners.
    run_op("msb_kept", 8'd255, 8'd255, 1, 9, 0, 1'b0);
    check("msb_kept/const", 64'(ref_bam(8'd255, 8'd255, 1, 9)), 64'h0000_F000);
    run_op("exact_max", 8'd255, 8'd255, 0, 0, 0, 1'b0);
    check("exact_max/const", 64'(ref_bam(8'd255, 8'd255, 0, 0)), 64'd65025);
    run_op("h1_200x3", 8'd200, 8'd3, 1, 0, 0, 1'b0);
    check("h1_200x3/const", 64'(ref_bam(8'd200, 8'd3, 1, 0)), 64'd400);
    run_op("h8_zero", 8'd200, 8'd3, 8, 0, 0, 1'b0);
    run_op("v16_zero", 8'd200, 8'd3, 0, 16, 0, 1'b0);
    run_op("v15_top", 8'd255, 8'd255, 0, 15, 0, 1'b0);

    // Hold the result five cycles while new requests are offered.
    run_op("stall5", 8'd123, 8'd45, 2, 3, 5, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      check("stall5/no_ghost_valid", 64'(out_valid), 64'd0);
      check("stall5/no_ghost_ready", 64'(in_ready), 64'd1);
    end

    // Abort in the middle of BUSY at row 3.
    @(negedge clk);
    in_a = 8'd99; in_b = 8'd77; in_h = '0; in_v = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort/out_valid", 64'(out_valid), 64'd0);
    check("abort/out_p", 64'(out_p), 64'd0);
    check("abort/in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    run_op("after_abort", 8'd99, 8'd77, 0, 0, 0, 1'b0);

    // Exact-mode sweep against plain multiplication.
    for (int k = 0; k < 200; k++) begin
      logic [N-1:0] a_r;
      logic [N-1:0] b_r;
      a_r = N'($urandom);
      b_r = N'($urandom);
      run_op("exact_rand", a_r, b_r, 0, 0, 0, 1'b0);
      check("exact_rand/arith", 64'(ref_bam(a_r, b_r, 0, 0)), 64'(a_r) * 64'(b_r));
    end

    // Fully random operations with random consumer stalls.
    for (int k = 0; k < 2000; k++) begin
      h_r = int'($urandom_range(N, 0));
      v_r = int'($urandom_range(2 * N, 0));
      run_op("rand", N'($urandom), N'($urandom), h_r, v_r,
             int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
